trigger_conditioner: RTL

//  Front end for pulse_generator: converts a raw, asynchronous, bouncy input (button/ext strobe)

---
 rtl/trigger_conditioner_if.sv | 32 +++
 rtl/trigger_conditioner.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/trigger_conditioner_if.sv
// Signal bundle between a trigger source and its consumer: raw button/strobe
// and enable in, conditioned trigger plus status out.
interface trigger_conditioner_if #(
    parameter int DROP_W = 8
);
    logic              btn_in;
    logic              en;
    logic              trigger;
    logic              level;
    logic              busy;
    logic [DROP_W-1:0] drop_cnt;

    // Stimulus side: drives the raw input and enable, observes the results.
    modport master (
        output btn_in,
        output en,
        input  trigger,
        input  level,
        input  busy,
        input  drop_cnt
    );

    // Conditioner side.
    modport slave (
        input  btn_in,
        input  en,
        output trigger,
        output level,
        output busy,
        output drop_cnt
    );
endinterface

// File: rtl/trigger_conditioner.sv
// Turns a raw, asynchronous, bouncy input into a clean one-cycle trigger:
// two-flop synchronizer, counter debouncer, rising-edge one-shot, and a
// holdoff lockout that rejects (and counts) edges arriving too soon.
module trigger_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 8,
    parameter int DROP_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    trigger_conditioner_if.slave  bus
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LOAD  = HW'(HOLDOFF_CYCLES);
    localparam logic [HW-1:0] H_LAST  = HW'(1);

    // FIRE is the single trigger cycle; HOLDOFF spans the busy window after it.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    logic              sync1_reg;
    logic              sync2_reg;
    logic              level_reg;
    logic              level_next;
    logic [DW-1:0]     dcnt_reg;
    logic [DW-1:0]     dcnt_next;
    logic              rise;

    state_t            state_reg;
    logic              trigger_reg;
    logic              busy_reg;
    logic [HW-1:0]     hcnt_reg;
    logic [DROP_W-1:0] drop_cnt_reg;
    logic              drop_sat;

    // Two-flop synchronizer; only sync2 is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= bus.btn_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce: a new level must be seen on DEBOUNCE_CYCLES consecutive samples;
    // any sample matching the current level restarts the count.
    always_comb begin
        dcnt_next  = dcnt_reg;
        level_next = level_reg;
        if (sync2_reg == level_reg) begin
            dcnt_next = '0;
        end else if (dcnt_reg == DB_LAST) begin
            level_next = sync2_reg;
            dcnt_next  = '0;
        end else begin
            dcnt_next = dcnt_reg + 1'b1;
        end
    end

    // Rising edge of the debounced level, seen one edge early so the
    // registered trigger lines up with the first high cycle of level.
    assign rise     = level_next & ~level_reg;
    assign drop_sat = &drop_cnt_reg;

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg <= 1'b0;
            dcnt_reg  <= '0;
        end else begin
            level_reg <= level_next;
            dcnt_reg  <= dcnt_next;
        end
    end

    // One-shot and holdoff FSM with registered trigger, busy and drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            trigger_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            hcnt_reg     <= '0;
            drop_cnt_reg <= '0;
        end else begin
            trigger_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rise && bus.en) begin
                        trigger_reg <= 1'b1;
                        state_reg   <= FIRE;
                    end
                end
                FIRE: begin
                    busy_reg  <= 1'b1;
                    hcnt_reg  <= H_LOAD;
                    state_reg <= HOLDOFF;
                    if (rise && !drop_sat) begin
                        drop_cnt_reg <= drop_cnt_reg + 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (hcnt_reg == H_LAST) begin
                        // Last busy cycle: an edge landing now shows up just
                        // after the window closes, so it is accepted.
                        busy_reg <= 1'b0;
                        hcnt_reg <= '0;
                        if (rise && bus.en) begin
                            trigger_reg <= 1'b1;
                            state_reg   <= FIRE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        hcnt_reg <= hcnt_reg - 1'b1;
                        if (rise && !drop_sat) begin
                            drop_cnt_reg <= drop_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    hcnt_reg  <= '0;
                end
            endcase
        end
    end

    assign bus.trigger  = trigger_reg;
    assign bus.level    = level_reg;
    assign bus.busy     = busy_reg;
    assign bus.drop_cnt = drop_cnt_reg;

endmodule
